// File: rtl/mapa_pkg.sv
// Shared definitions for the snake map: tile codes, palette, and the fetch FSM encoding.
package mapa_pkg;

  typedef enum logic [1:0] {
    VAZIO     = 2'd0,
    COBRA     = 2'd1,
    FRUTA     = 2'd2,
    OBSTACULO = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t COR_PRETO     = rgb_t'(24'h000000);
  localparam rgb_t COR_COBRA     = rgb_t'(24'h00FF00);
  localparam rgb_t COR_FRUTA     = rgb_t'(24'hFF0000);
  localparam rgb_t COR_OBSTACULO = rgb_t'(24'h808080);
  localparam rgb_t COR_GRADE     = rgb_t'(24'h202020);

  function automatic rgb_t tile_colour(input tile_t t);
    rgb_t c;
    case (t)
      COBRA:     c = COR_COBRA;
      FRUTA:     c = COR_FRUTA;
      OBSTACULO: c = COR_OBSTACULO;
      default:   c = COR_PRETO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mapa_linebuf.sv
// One tile row of the map: single write port, asynchronous read port, synchronous clear.
module mapa_linebuf #(
  parameter int DEPTH = 40,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [1:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [1:0]    o_rdata
);

  logic [1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
    end else if (i_we && (int'(i_waddr) < DEPTH)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Addresses past the row (possible when DEPTH is not a power of two) read as empty.
  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : 2'b00;

endmodule

// File: rtl/mapa_render.sv
// Map renderer: fetches one tile row into a line buffer during horizontal blank, then paints pixels.
// Optional MAPA_RENDER_GRID_EN overlays a dim grid on empty tiles.
module mapa_render
  import mapa_pkg::*;
#(
  parameter int MAPA_WIDTH  = 40,
  parameter int MAPA_HEIGHT = 30,
  parameter int TILE_SIZE   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_start,
  input  logic [9:0] line_y,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       vga_active,
  output logic       render_renable,
  output logic [9:0] render_rx,
  output logic [9:0] render_ry,
  input  logic [1:0] render_rdata,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       fetch_busy,
  output state_t     dbg_state
);

  localparam int          TS_LOG    = $clog2(TILE_SIZE);
  localparam int          AW        = (MAPA_WIDTH > 1) ? $clog2(MAPA_WIDTH) : 1;
  localparam logic [10:0] MAP_W_PIX = 11'(MAPA_WIDTH * TILE_SIZE);
  localparam logic [10:0] MAP_H_PIX = 11'(MAPA_HEIGHT * TILE_SIZE);
  localparam logic [9:0]  TS_MASK   = 10'(TILE_SIZE - 1);
  localparam logic [9:0]  LAST_COL  = 10'(MAPA_WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [9:0]      r_col;
  logic [9:0]      r_row;
  logic            r_wr_valid;
  logic [AW-1:0]   r_wr_addr;
  logic            w_start;
  logic [AW-1:0]   w_rd_addr;
  logic [1:0]      w_tile;
  logic            w_in_map;
  rgb_t            w_pix;
  rgb_t            r_pix;

  // A fetch begins only on the first pixel row of a tile row inside the map.
  assign w_start = line_start && (r_state == IDLE) &&
                   ({1'b0, line_y} < MAP_H_PIX) && ((line_y & TS_MASK) == 10'd0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = FETCH;
      FETCH:   if (r_col == LAST_COL) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read data returns one cycle after its strobe, so the write trails the issued column by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= 10'd0;
      r_row      <= 10'd0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_wr_valid <= (r_state == FETCH);
      r_wr_addr  <= AW'(r_col);
      if (w_start) begin
        r_col <= 10'd0;
        r_row <= line_y >> TS_LOG;
      end else if (r_state == FETCH) begin
        r_col <= r_col + 10'd1;
      end
    end
  end

  assign render_renable = (r_state == FETCH);
  assign render_rx      = render_renable ? r_col : 10'd0;
  assign render_ry      = render_renable ? r_row : 10'd0;
  assign fetch_busy     = (r_state == FETCH) || (r_state == DRAIN);
  assign dbg_state      = r_state;

  assign w_rd_addr = AW'(vga_x >> TS_LOG);

  mapa_linebuf #(
    .DEPTH (MAPA_WIDTH),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .reset   (reset),
    .i_we    (r_wr_valid),
    .i_waddr (r_wr_addr),
    .i_wdata (render_rdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_tile)
  );

  assign w_in_map = vga_active && ({1'b0, vga_x} < MAP_W_PIX);

  always_comb begin
    w_pix = COR_PRETO;
    if (w_in_map) w_pix = tile_colour(tile_t'(w_tile));
`ifdef MAPA_RENDER_GRID_EN
    if (w_in_map && ({1'b0, vga_y} < MAP_H_PIX) && (tile_t'(w_tile) == VAZIO) &&
        (((vga_x & TS_MASK) == 10'd0) || ((vga_y & TS_MASK) == 10'd0)))
      w_pix = COR_GRADE;
`endif
  end

`ifndef MAPA_RENDER_GRID_EN
  logic w_unused_y;
  assign w_unused_y = ^vga_y;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_pix <= COR_PRETO;
    else       r_pix <= w_pix;
  end

  assign vga_r = r_pix.r;
  assign vga_g = r_pix.g;
  assign vga_b = r_pix.b;

endmodule

// File: tb/tb_mapa_render.sv
// Directed bench for mapa_render: row fetch timing, palette, blanking, overlap, reset abort, grid.
module tb_mapa_render;
  import mapa_pkg::*;

  logic       clk;
  logic       reset;
  logic       line_start;
  logic [9:0] line_y;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic       vga_active;
  logic       render_renable;
  logic [9:0] render_rx;
  logic [9:0] render_ry;
  logic [1:0] render_rdata;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       fetch_busy;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  logic [1:0] mem [0:1199];

  mapa_render dut (
    .clk            (clk),
    .reset          (reset),
    .line_start     (line_start),
    .line_y         (line_y),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_active     (vga_active),
    .render_renable (render_renable),
    .render_rx      (render_rx),
    .render_ry      (render_ry),
    .render_rdata   (render_rdata),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .fetch_busy     (fetch_busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Map memory model: data returns one cycle after the strobe.
  always @(posedge clk) begin
    if (render_renable && (int'(render_ry) < 30) && (int'(render_rx) < 40))
      render_rdata <= mem[int'(render_ry) * 40 + int'(render_rx)];
    else
      render_rdata <= 2'b00;
  end

  function automatic logic [23:0] exp_colour(input logic [1:0] code);
    case (code)
      2'd1:    return 24'h00FF00;
      2'd2:    return 24'hFF0000;
      2'd3:    return 24'h808080;
      default: return 24'h000000;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pulse_line(input logic [9:0] y);
    line_y     = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, input logic a);
    vga_x      = x;
    vga_y      = y;
    vga_active = a;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (fetch_busy && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: fetch_busy=%b still high after %0d cycles, required 0", fetch_busy, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (render_renable !== 1'b0 || render_rx !== 10'd0 || render_ry !== 10'd0 ||
        fetch_busy !== 1'b0 || dbg_state !== IDLE || {vga_r, vga_g, vga_b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: ren=%b rx=%0d ry=%0d busy=%b st=%0d rgb=%h, required all zero/IDLE",
               render_renable, render_rx, render_ry, fetch_busy, dbg_state, {vga_r, vga_g, vga_b});
    end
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      drive_pixel(10'(c * 16 + 5), 10'd5, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== 24'h0) begin
        errors++;
        $display("FAIL reset_buffer col %0d: rgb=%h, required 000000", c, {vga_r, vga_g, vga_b});
      end
    end
  endtask

  task automatic test_row_fetch();
    int busy_cycles = 0;
    pulse_line(10'd32);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (render_renable !== 1'b1 || render_rx !== 10'(k) || render_ry !== 10'd2 || fetch_busy !== 1'b1) begin
        errors++;
        $display("FAIL row_fetch cycle %0d: ren=%b rx=%0d ry=%0d busy=%b, required 1/%0d/2/1",
                 k, render_renable, render_rx, render_ry, fetch_busy, k);
      end
      if (fetch_busy) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (render_renable !== 1'b0 || render_rx !== 10'd0 || render_ry !== 10'd0 ||
        fetch_busy !== 1'b1 || dbg_state !== DRAIN) begin
      errors++;
      $display("FAIL row_fetch_drain: ren=%b rx=%0d ry=%0d busy=%b st=%0d, required 0/0/0/1/DRAIN",
               render_renable, render_rx, render_ry, fetch_busy, dbg_state);
    end
    if (fetch_busy) busy_cycles++;
    @(negedge clk);
    checks++;
    if (fetch_busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL row_fetch_end: busy=%b st=%0d, required 0/IDLE", fetch_busy, dbg_state);
    end
    checks++;
    if (busy_cycles != 41) begin
      errors++;
      $display("FAIL row_fetch_busy_len: %0d cycles, required 41", busy_cycles);
    end
    for (int c = 0; c < 40; c++) begin
      drive_pixel(10'(c * 16 + 7), 10'd37, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_colour(mem[2 * 40 + c])) begin
        errors++;
        $display("FAIL row_fetch_pixel col %0d: rgb=%h, required %h",
                 c, {vga_r, vga_g, vga_b}, exp_colour(mem[2 * 40 + c]));
      end
    end
  endtask

  task automatic test_colour();
    logic [9:0]  xs  [7] = '{10'd165, 10'd245, 10'd159, 10'd160, 10'd639, 10'd640, 10'd250};
    logic        act [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [23:0] exp [7] = '{24'h00FF00, 24'hFF0000, 24'h000000, 24'h00FF00,
                             24'h808080, 24'h000000, 24'h000000};
    pulse_line(10'd0);
    wait_idle(60);
    for (int i = 0; i < 7; i++) begin
      drive_pixel(xs[i], 10'd5, act[i]);
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp[i]) begin
        errors++;
        $display("FAIL colour x=%0d act=%b: rgb=%h, required %h", xs[i], act[i], {vga_r, vga_g, vga_b}, exp[i]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [9:0] ys [3] = '{10'd480, 10'd17, 10'd500};
    for (int i = 0; i < 3; i++) begin
      int strobes = 0;
      pulse_line(ys[i]);
      for (int n = 0; n < 45; n++) begin
        if (render_renable || fetch_busy) strobes++;
        @(negedge clk);
      end
      checks++;
      if (strobes != 0) begin
        errors++;
        $display("FAIL blanking line_y=%0d: %0d busy/strobe cycles, required 0", ys[i], strobes);
      end
    end
    drive_pixel(10'd165, 10'd5, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h00FF00) begin
      errors++;
      $display("FAIL blanking_buffer_kept: rgb=%h, required 00ff00", {vga_r, vga_g, vga_b});
    end
    drive_pixel(10'd165, 10'd5, 1'b0);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      errors++;
      $display("FAIL blanking_inactive: rgb=%h, required 000000", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_last_row();
    pulse_line(10'd464);
    checks++;
    if (render_renable !== 1'b1 || render_ry !== 10'd29 || render_rx !== 10'd0) begin
      errors++;
      $display("FAIL last_row_start: ren=%b rx=%0d ry=%0d, required 1/0/29", render_renable, render_rx, render_ry);
    end
    wait_idle(60);
    drive_pixel(10'd5, 10'd470, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h808080) begin
      errors++;
      $display("FAIL last_row_pixel: rgb=%h, required 808080", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_busy_overlap();
    int strobes = 0;
    pulse_line(10'd32);
    for (int i = 0; i < 60; i++) begin
      if (i == 5) begin
        line_y     = 10'd0;
        line_start = 1'b1;
      end else begin
        line_start = 1'b0;
      end
      if (render_renable) begin
        strobes++;
        if (render_ry !== 10'd2) begin
          checks++;
          errors++;
          $display("FAIL overlap_row: ry=%0d, required 2", render_ry);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (strobes != 40) begin
      errors++;
      $display("FAIL overlap_strobes: %0d strobes, required 40", strobes);
    end
    drive_pixel(10'd165, 10'd5, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin
      errors++;
      $display("FAIL overlap_buffer x=165: rgb=%h, required ff0000", {vga_r, vga_g, vga_b});
    end
    drive_pixel(10'd21, 10'd5, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h00FF00) begin
      errors++;
      $display("FAIL overlap_buffer x=21: rgb=%h, required 00ff00", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_reset_mid_fetch();
    int strobes = 0;
    pulse_line(10'd0);
    repeat (10) @(negedge clk);
    checks++;
    if (render_rx !== 10'd10 || render_renable !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: ren=%b rx=%0d, required 1/10", render_renable, render_rx);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (render_renable !== 1'b0 || fetch_busy !== 1'b0 || dbg_state !== IDLE || render_rx !== 10'd0) begin
      errors++;
      $display("FAIL midreset_abort: ren=%b busy=%b st=%0d rx=%0d, required 0/0/IDLE/0",
               render_renable, fetch_busy, dbg_state, render_rx);
    end
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (render_renable || fetch_busy) strobes++;
      @(negedge clk);
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL midreset_resume: %0d busy cycles after reset, required 0", strobes);
    end
    for (int c = 0; c < 40; c++) begin
      drive_pixel(10'(c * 16 + 5), 10'd5, 1'b1);
      checks++;
      if ({vga_r, vga_g, vga_b} !== 24'h0) begin
        errors++;
        $display("FAIL midreset_buffer col %0d: rgb=%h, required 000000", c, {vga_r, vga_g, vga_b});
      end
    end
  endtask

  task automatic test_grid();
    logic [23:0] g;
`ifdef MAPA_RENDER_GRID_EN
    g = 24'h202020;
`else
    g = 24'h000000;
`endif
    drive_pixel(10'd16, 10'd3, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== g) begin
      errors++;
      $display("FAIL grid_x_line: rgb=%h, required %h", {vga_r, vga_g, vga_b}, g);
    end
    drive_pixel(10'd20, 10'd16, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== g) begin
      errors++;
      $display("FAIL grid_y_line: rgb=%h, required %h", {vga_r, vga_g, vga_b}, g);
    end
    drive_pixel(10'd17, 10'd3, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      errors++;
      $display("FAIL grid_off_line: rgb=%h, required 000000", {vga_r, vga_g, vga_b});
    end
    drive_pixel(10'd640, 10'd0, 1'b1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
      errors++;
      $display("FAIL grid_outside_map: rgb=%h, required 000000", {vga_r, vga_g, vga_b});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = 2'b00;
    mem[10] = 2'd1;
    mem[15] = 2'd2;
    mem[39] = 2'd3;
    for (int c = 0; c < 40; c++) mem[2 * 40 + c] = 2'(c);
    for (int c = 0; c < 40; c++) mem[29 * 40 + c] = 2'd3;

    reset      = 1'b1;
    line_start = 1'b0;
    line_y     = 10'd0;
    vga_x      = 10'd0;
    vga_y      = 10'd0;
    vga_active = 1'b0;
    @(negedge clk);

    test_reset();
    test_row_fetch();
    test_colour();
    test_blanking();
    test_last_row();
    test_busy_overlap();
    test_reset_mid_fetch();
    test_grid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
